// File: rtl/sb_mem_resp.sv
// System-bus memory responder: word RAM with a free-running fetch port and a
// wait-stated load/store FSM. Define SB_ACCESS_ERR_EN to add the err port.
module sb_mem_resp #(
    parameter int unsigned MEM_DEPTH   = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [3:0]  byte_mask,
    input  logic        un_sign,
    input  logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy
`ifdef SB_ACCESS_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    logic [31:0] ram [MEM_DEPTH];

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    logic [31:0] addr_q;
    logic [3:0]  mask_q;
    logic [31:0] wdata_q;
    logic        un_q;
    logic        rd_q;

    logic        req;
    logic        idle;

    assign req  = mem_re | mem_we;
    assign idle = (state_q == S_IDLE);
    assign busy = !idle;

    // ---------------- fetch port ----------------
    logic [32:0] f_off;
    logic [31:0] f_idx;
    logic        f_ok;

    assign f_off = {1'b0, inst_addr} - {1'b0, ADDR_BASE};
    assign f_idx = f_off[31:0] >> 2;
    assign f_ok  = !f_off[32] && (f_idx < MEM_DEPTH);

    // ---------------- access operands ----------------
    // With no wait states the access edge is the request edge, so the
    // live bus is used; otherwise the latched copy is.
    logic [31:0] acc_addr;
    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic        acc_un;
    logic        acc_rd;
    logic        acc_go;

    assign acc_addr  = idle ? addr      : addr_q;
    assign acc_mask  = idle ? byte_mask : mask_q;
    assign acc_wdata = idle ? mem_wdata : wdata_q;
    assign acc_un    = idle ? un_sign   : un_q;
    assign acc_rd    = idle ? mem_re    : rd_q;

    assign acc_go = (idle && req && (WAIT_CYCLES == 0))
                  || ((state_q == S_WAIT) && (cnt_q == 4'd0));

    logic [32:0] d_off;
    logic [31:0] d_idx;
    logic        d_ok;

    assign d_off = {1'b0, acc_addr} - {1'b0, ADDR_BASE};
    assign d_idx = d_off[31:0] >> 2;
    assign d_ok  = !d_off[32] && (d_idx < MEM_DEPTH);

    // ---------------- lane decode ----------------
    logic        legal;
    logic [1:0]  lane;
    size_t       sz;
    logic        misal;

    always_comb begin
        legal = 1'b1;
        lane  = 2'd0;
        sz    = SZ_BYTE;
        unique case (1'b1)
            (acc_mask == 4'b0001): lane = 2'd0;
            (acc_mask == 4'b0010): lane = 2'd1;
            (acc_mask == 4'b0100): lane = 2'd2;
            (acc_mask == 4'b1000): lane = 2'd3;
            (acc_mask == 4'b0011): sz = SZ_HALF;
            (acc_mask == 4'b1100): begin
                lane = 2'd2;
                sz   = SZ_HALF;
            end
            (acc_mask == 4'b1111): sz = SZ_WORD;
            default: legal = 1'b0;
        endcase
    end

`ifdef SB_ACCESS_ERR_EN
    assign misal = ((acc_mask == 4'b0011) && (acc_addr[1:0] != 2'b00))
                || ((acc_mask == 4'b1100) && (acc_addr[1:0] != 2'b10))
                || ((acc_mask == 4'b1111) && (acc_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    logic bad;
    assign bad = !d_ok || !legal || misal;

    // ---------------- load extraction ----------------
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign word    = ram[d_idx[AW-1:0]];
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        ext = shifted;
        unique case (sz)
            SZ_BYTE: ext = acc_un ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = acc_un ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            inst        <= 32'h0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
`ifdef SB_ACCESS_ERR_EN
            err         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst        <= f_ok ? ram[f_idx[AW-1:0]] : 32'h0000_0013;
            rdata_valid <= acc_go && acc_rd;
            if (acc_go && acc_rd) begin
                rdata <= bad ? 32'h0 : ext;
            end
`ifdef SB_ACCESS_ERR_EN
            err         <= acc_go && bad;
`endif
        end
    end

    // request capture; read wins when both strobes are high
    always_ff @(posedge clk) begin
        if (idle && req) begin
            addr_q  <= addr;
            mask_q  <= byte_mask;
            wdata_q <= mem_wdata;
            un_q    <= un_sign;
            rd_q    <= mem_re;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc_go && !acc_rd && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    ram[d_idx[AW-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_mem_resp.sv
// Directed bench for sb_mem_resp: a zero-wait instance and a 3-wait instance
// driven side by side with hand-computed expectations.
module tb_sb_mem_resp;

    logic        clk;
    logic        rst    [2];
    logic [31:0] finst  [2];
    logic [31:0] inst   [2];
    logic        re     [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [3:0]  mask   [2];
    logic        uns    [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        rvalid [2];
    logic        busy   [2];
`ifdef SB_ACCESS_ERR_EN
    logic        errp   [2];
`endif

    int checks = 0;
    int errors = 0;

    sb_mem_resp #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst[0]),
        .inst_addr(finst[0]), .inst(inst[0]),
        .mem_re(re[0]), .mem_we(we[0]), .addr(addr[0]),
        .byte_mask(mask[0]), .un_sign(uns[0]),
        .mem_wdata(wdata[0]), .rdata(rdata[0]),
        .rdata_valid(rvalid[0]), .busy(busy[0])
`ifdef SB_ACCESS_ERR_EN
        , .err(errp[0])
`endif
    );

    sb_mem_resp #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst[1]),
        .inst_addr(finst[1]), .inst(inst[1]),
        .mem_re(re[1]), .mem_we(we[1]), .addr(addr[1]),
        .byte_mask(mask[1]), .un_sign(uns[1]),
        .mem_wdata(wdata[1]), .rdata(rdata[1]),
        .rdata_valid(rvalid[1]), .busy(busy[1])
`ifdef SB_ACCESS_ERR_EN
        , .err(errp[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int wcyc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic issue(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [3:0] m,
                         input logic us, input logic [31:0] wd);
        @(negedge clk);
        re[d] = r; we[d] = w; addr[d] = a;
        mask[d] = m; uns[d] = us; wdata[d] = wd;
        @(posedge clk);
        #1;
        re[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic watch(input int d, output int nb, output int nv,
                         output int vat, output int ne,
                         output logic [31:0] rd);
        nb = 0; nv = 0; vat = 0; ne = 0; rd = 32'h0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (busy[d]) nb++;
            if (rvalid[d]) begin
                nv++;
                vat = n;
                rd = rdata[d];
            end
`ifdef SB_ACCESS_ERR_EN
            if (errp[d]) ne++;
`endif
            if (!busy[d]) break;
        end
    endtask

    task automatic xfer(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [3:0] m,
                        input logic us, input logic [31:0] wd,
                        output int nb, output int nv, output int vat,
                        output int ne, output logic [31:0] rd);
        issue(d, r, w, a, m, us, wd);
        watch(d, nb, nv, vat, ne, rd);
    endtask

    task automatic load(input int d, input logic [31:0] a,
                        input logic [3:0] m, input logic us,
                        input logic [31:0] exp, input string tag);
        int nb, nv, vat, ne;
        logic [31:0] rd;
        xfer(d, 1'b1, 1'b0, a, m, us, 32'h0, nb, nv, vat, ne, rd);
        check(tag, rd, exp);
        check({tag, "_lat"}, vat, wcyc(d) + 1);
    endtask

    task automatic store(input int d, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] wd,
                         input string tag);
        int nb, nv, vat, ne;
        logic [31:0] rd;
        xfer(d, 1'b0, 1'b1, a, m, 1'b0, wd, nb, nv, vat, ne, rd);
        check({tag, "_busy"}, nb, wcyc(d) + 1);
        check({tag, "_nv"}, nv, 0);
    endtask

    initial begin
        int nb, nv, vat, ne;
        logic [31:0] rd;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; finst[d] = 32'h0; re[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 32'h0; mask[d] = 4'h0; uns[d] = 1'b0; wdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_inst", inst[0], 32'h0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_valid", rvalid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_busy3", busy[1], 0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // fetch
        store(0, 32'd0, 4'b1111, 32'hDEADBEEF, "st_w0");
        finst[0] = 32'd0;
        @(negedge clk);
        check("fetch0", inst[0], 32'hDEADBEEF);
        finst[0] = 32'd16384;
        @(negedge clk);
        check("fetch_oor", inst[0], 32'h0000_0013);

        // fetch sees the old word on a same-edge store
        finst[0] = 32'd0;
        issue(0, 1'b0, 1'b1, 32'd0, 4'b1111, 1'b0, 32'h12345678);
        @(negedge clk);
        check("fetch_rbw_old", inst[0], 32'hDEADBEEF);
        @(negedge clk);
        check("fetch_rbw_new", inst[0], 32'h12345678);

        // byte and half loads, zero wait
        store(0, 32'd4, 4'b1111, 32'h80FF7F01, "st_w1");
        xfer(0, 1'b1, 1'b0, 32'd5, 4'b0010, 1'b0, 32'h0, nb, nv, vat, ne, rd);
        check("lb1", rd, 32'h0000007F);
        check("lb1_busy", nb, 1);
        check("lb1_nv", nv, 1);
        load(0, 32'd6, 4'b0100, 1'b0, 32'hFFFFFFFF, "lb2_s");
        load(0, 32'd7, 4'b1000, 1'b1, 32'h00000080, "lb3_u");
        load(0, 32'd7, 4'b1000, 1'b0, 32'hFFFFFF80, "lb3_s");
        load(0, 32'd4, 4'b0011, 1'b0, 32'h00007F01, "lh0_s");
        load(0, 32'd6, 4'b1100, 1'b1, 32'h000080FF, "lh1_u");
        load(0, 32'd6, 4'b1100, 1'b0, 32'hFFFF80FF, "lh1_s");

        // half store then load, three wait states
        store(1, 32'd8, 4'b1111, 32'h11112222, "st3_w2");
        store(1, 32'd10, 4'b1100, 32'hABCD0000, "st3_h");
        load(1, 32'd10, 4'b1100, 1'b0, 32'hFFFFABCD, "lh3_s");
        load(1, 32'd8, 4'b1111, 1'b0, 32'hABCD2222, "lw3");

        // requests pulsed while busy are ignored
        issue(1, 1'b1, 1'b0, 32'd8, 4'b1111, 1'b0, 32'h0);
        nb = 0; nv = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (busy[1]) nb++;
            if (rvalid[1]) nv++;
            if (n == 2) begin
                we[1] = 1'b1; addr[1] = 32'd8;
                mask[1] = 4'b1111; wdata[1] = 32'h0;
            end else begin
                we[1] = 1'b0;
            end
            if (!busy[1] && n > 1) break;
        end
        check("hold_nv", nv, 1);
        check("hold_busy", nb, 4);
        load(1, 32'd8, 4'b1111, 1'b0, 32'hABCD2222, "hold_ram");

        // read wins over a simultaneous write
        xfer(0, 1'b1, 1'b1, 32'd0, 4'b1111, 1'b0, 32'h0, nb, nv, vat, ne, rd);
        check("rw_rdata", rd, 32'h12345678);
        check("rw_nv", nv, 1);
        load(0, 32'd0, 4'b1111, 1'b0, 32'h12345678, "rw_ram");

        // reset during WAIT discards a pending store
        store(1, 32'd12, 4'b1111, 32'h0, "st3_w3");
        issue(1, 1'b0, 1'b1, 32'd12, 4'b1111, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy[1], 0);
        check("mid_rst_valid", rvalid[1], 0);
        rst[1] = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy[1], 0);
        check("post_rst_valid", rvalid[1], 0);
        load(1, 32'd12, 4'b1111, 1'b0, 32'h0, "mid_rst_ram");

        // illegal mask store and load
        xfer(0, 1'b0, 1'b1, 32'd4, 4'b0101, 1'b0, 32'hFFFFFFFF,
             nb, nv, vat, ne, rd);
`ifdef SB_ACCESS_ERR_EN
        check("ill_st_err", ne, 1);
`endif
        check("ill_st_nv", nv, 0);
        load(0, 32'd4, 4'b1111, 1'b0, 32'h80FF7F01, "ill_st_ram");
        load(0, 32'd4, 4'b0110, 1'b0, 32'h0, "ill_ld");

        // out-of-range load and store
        load(0, 32'd4, 4'b1111, 1'b0, 32'h80FF7F01, "pre_oor");
        load(0, 32'd16384, 4'b1111, 1'b0, 32'h0, "oor_ld");
        store(0, 32'd16384, 4'b1111, 32'h0, "oor_st");
        load(0, 32'd0, 4'b1111, 1'b0, 32'h12345678, "oor_st_ram");

        // misaligned word load
        xfer(0, 1'b1, 1'b0, 32'd2, 4'b1111, 1'b0, 32'h0, nb, nv, vat, ne, rd);
`ifdef SB_ACCESS_ERR_EN
        check("mis_ld", rd, 32'h0);
        check("mis_err", ne, 1);
`else
        check("mis_ld", rd, 32'h12345678);
`endif
        check("mis_nv", nv, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
